// File: rtl/comm_stream_chan.sv
// Host byte-stream command parser driving channel pipes; data phases are combinational pass-through,
// zero added latency. Backpressure from either side stalls state and count; nothing is dropped.
module comm_stream_chan #(
  parameter int LEN_BYTES = 4
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic [7:0] hostData_in,
  input  logic       hostValid_in,
  output logic       hostReady_out,
  output logic [7:0] hostData_out,
  output logic       hostValid_out,
  input  logic       hostReady_in,
  output logic [6:0] chanAddr_out,
  output logic [7:0] h2fData_out,
  output logic       h2fValid_out,
  input  logic       h2fReady_in,
  input  logic [7:0] f2hData_in,
  input  logic       f2hValid_in,
  output logic       f2hReady_out,
  output logic       busy_out
);

  localparam int CW = 8 * LEN_BYTES;

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_WRITE, S_READ} state_t;

  state_t          state;
  logic            is_read;
  logic [6:0]      chan;
  logic [CW-1:0]   count;
  logic [1:0]      byte_idx;
  logic [CW-1:0]   len_next;
  logic            last_len;
  logic            host_xfer;
  logic            f2h_xfer;

  assign len_next  = (count << 8) | CW'(hostData_in);
  assign last_len  = (byte_idx == 2'(LEN_BYTES - 1));
  assign host_xfer = hostValid_in & hostReady_out;
  assign f2h_xfer  = f2hValid_in & f2hReady_out;

  assign chanAddr_out = chan;
  assign busy_out     = (state != S_IDLE);

  // Gated by reset so the host sees not-ready while reset is held.
  always_comb begin
    hostReady_out = 1'b0;
    h2fData_out   = 8'h00;
    h2fValid_out  = 1'b0;
    hostData_out  = 8'h00;
    hostValid_out = 1'b0;
    f2hReady_out  = 1'b0;
    if (reset_n_in) begin
      case (state)
        S_IDLE, S_LEN: hostReady_out = 1'b1;
        S_WRITE: begin
          h2fData_out   = hostData_in;
          h2fValid_out  = hostValid_in;
          hostReady_out = h2fReady_in;
        end
        S_READ: begin
          hostData_out  = f2hData_in;
          hostValid_out = f2hValid_in;
          f2hReady_out  = hostReady_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state    <= S_IDLE;
      is_read  <= 1'b0;
      chan     <= 7'd0;
      count    <= '0;
      byte_idx <= 2'd0;
    end else begin
      case (state)
        S_IDLE: if (host_xfer) begin
          chan     <= hostData_in[6:0];
          is_read  <= hostData_in[7];
          count    <= '0;
          byte_idx <= 2'd0;
          state    <= S_LEN;
        end
        S_LEN: if (host_xfer) begin
          count    <= len_next;
          byte_idx <= byte_idx + 2'd1;
          if (last_len) begin
            if (len_next == '0) state <= S_IDLE;
            else                state <= is_read ? S_READ : S_WRITE;
          end
        end
        S_WRITE: if (host_xfer) begin
          if (count != '0) count <= count - 1'b1;
          if (count <= CW'(1)) state <= S_IDLE;
        end
        S_READ: if (f2h_xfer) begin
          if (count != '0) count <= count - 1'b1;
          if (count <= CW'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
